fleet_controller: RTL and testbench

Game-level sequencer for the invader formation. It owns the 8x3 formation origin, the march pattern (sideways steps, then a descent), and the alive mask. It arbitrates invader hits reported by the player-bullet collision logic and schedules enemy shots. It exposes the game state (IDLE/PLAY/WIN/LOSE) to the top level, the sprite instances and the ammunition blocks.

---
 rtl/fleet_controller.sv | 214 +++++++++++++++++++++
 tb/tb_fleet_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fleet_controller.sv
// Invader fleet sequencer: formation march, hit arbitration, win/lose detection
// and enemy-fire column search. Spec port names carry _i/_o suffixes ("rand" is reserved).
module fleet_controller #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROWS        = 3,
    parameter int unsigned X0          = 150,
    parameter int unsigned Y0          = 40,
    parameter int unsigned DX          = 60,
    parameter int unsigned DY          = 50,
    parameter int unsigned H_STEPS     = 3,
    parameter int unsigned STEP_PERIOD = 50000000,
    parameter int unsigned FIRE_PERIOD = 25000000,
    parameter int unsigned Y_LIMIT     = 400,
    parameter int unsigned FIRE_DX     = 8,
    parameter int unsigned FIRE_DY     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 hit_valid_i,
    input  logic [4:0]           hit_index_i,
    input  logic                 player_hit_i,
    input  logic                 shot_busy_i,
    input  logic [7:0]           rand_i,
    output logic [9:0]           fleet_x_o,
    output logic [9:0]           fleet_y_o,
    output logic [COLS*ROWS-1:0] alive_mask_o,
    output logic                 kill_ack_o,
    output logic                 fire_req_o,
    output logic [9:0]           fire_x_o,
    output logic [9:0]           fire_y_o,
    output logic [9:0]           score_o,
    output logic [1:0]           game_state_o
);
    localparam int unsigned N  = COLS * ROWS;
    localparam int unsigned SW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int unsigned FW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam int unsigned HW = (H_STEPS > 0) ? $clog2(H_STEPS + 1) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} game_e;
    typedef enum logic {F_WAIT, F_SEARCH} fire_e;

    game_e         state_q, state_d;
    fire_e         srch_q, srch_d;
    logic [9:0]    fleet_x_q, fleet_x_d, fleet_y_q, fleet_y_d;
    logic [N-1:0]  alive_q, alive_d;
    logic [9:0]    score_q, score_d;
    logic          dir_q, dir_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [FW-1:0] fire_cnt_q, fire_cnt_d;
    logic [CW-1:0] col_q, col_d, tries_q, tries_d;
    logic          kill_ack_q, kill_ack_d, fire_req_q, fire_req_d;
    logic [9:0]    fire_x_q, fire_x_d, fire_y_q, fire_y_d;

    logic [31:0]   alive_ext;
    logic          any_alive, col_hit, tick, hit_ok;
    logic [9:0]    low_row, col_row, bottom_y;

    always_comb begin
        state_d    = state_q;
        srch_d     = srch_q;
        fleet_x_d  = fleet_x_q;
        fleet_y_d  = fleet_y_q;
        alive_d    = alive_q;
        score_d    = score_q;
        dir_d      = dir_q;
        h_cnt_d    = h_cnt_q;
        step_d     = step_q;
        fire_cnt_d = fire_cnt_q;
        col_d      = col_q;
        tries_d    = tries_q;
        kill_ack_d = 1'b0;
        fire_req_d = 1'b0;
        fire_x_d   = fire_x_q;
        fire_y_d   = fire_y_q;

        // Padded copy keeps out-of-range hit indices from selecting past the mask.
        alive_ext = 32'(alive_q);
        any_alive = 1'b0;
        low_row   = '0;
        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                if (alive_ext[5'(r * COLS + c)]) begin
                    any_alive = 1'b1;
                    low_row   = 10'(r);
                end
        col_hit = 1'b0;
        col_row = '0;
        for (int unsigned r = 0; r < ROWS; r++)
            if (alive_ext[5'(r * COLS) + 5'(col_q)]) begin
                col_hit = 1'b1;
                col_row = 10'(r);
            end
        bottom_y = fleet_y_q + low_row * 10'(DY);
        tick     = (step_q == SW'(STEP_PERIOD - 1));
        hit_ok   = hit_valid_i && (hit_index_i < 5'(N)) && alive_ext[hit_index_i];

        case (state_q)
            IDLE: begin
                srch_d = F_WAIT;
                if (start_i) state_d = PLAY;
            end
            WIN, LOSE: begin
                srch_d = F_WAIT;
                if (start_i) begin
                    state_d    = PLAY;
                    fleet_x_d  = 10'(X0);
                    fleet_y_d  = 10'(Y0);
                    alive_d    = '1;
                    score_d    = '0;
                    dir_d      = 1'b0;
                    h_cnt_d    = '0;
                    step_d     = '0;
                    fire_cnt_d = '0;
                    col_d      = '0;
                    tries_d    = '0;
                    fire_x_d   = '0;
                    fire_y_d   = '0;
                end
            end
            PLAY: begin
                step_d = tick ? '0 : step_q + 1'b1;
                if (tick) begin
                    if (h_cnt_q < HW'(H_STEPS)) begin
                        fleet_x_d = dir_q ? fleet_x_q - 10'(DX) : fleet_x_q + 10'(DX);
                        h_cnt_d   = h_cnt_q + 1'b1;
                    end else begin
                        fleet_y_d = fleet_y_q + 10'(DY);
                        dir_d     = ~dir_q;
                        h_cnt_d   = '0;
                    end
                end
                if (hit_ok) begin
                    alive_d[hit_index_i] = 1'b0;
                    kill_ack_d           = 1'b1;
                    if (score_q != '1) score_d = score_q + 1'b1;
                end
                if (srch_q == F_WAIT) begin
                    if (fire_cnt_q == FW'(FIRE_PERIOD - 1)) begin
                        fire_cnt_d = '0;
                        if (!shot_busy_i) begin
                            srch_d  = F_SEARCH;
                            col_d   = CW'(rand_i % COLS);
                            tries_d = '0;
                        end
                    end else begin
                        fire_cnt_d = fire_cnt_q + 1'b1;
                    end
                end else if (col_hit) begin
                    fire_req_d = 1'b1;
                    fire_x_d   = fleet_x_q + 10'(col_q) * 10'(DX) + 10'(FIRE_DX);
                    fire_y_d   = fleet_y_q + col_row * 10'(DY) + 10'(FIRE_DY);
                    srch_d     = F_WAIT;
                end else begin
                    col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
                    tries_d = tries_q + 1'b1;
                    if (tries_q == CW'(COLS - 1)) srch_d = F_WAIT;
                end
                if (player_hit_i || (any_alive && bottom_y >= 10'(Y_LIMIT))) state_d = LOSE;
                else if (!any_alive) state_d = WIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            srch_q     <= F_WAIT;
            fleet_x_q  <= 10'(X0);
            fleet_y_q  <= 10'(Y0);
            alive_q    <= '1;
            score_q    <= '0;
            dir_q      <= 1'b0;
            h_cnt_q    <= '0;
            step_q     <= '0;
            fire_cnt_q <= '0;
            col_q      <= '0;
            tries_q    <= '0;
            kill_ack_q <= 1'b0;
            fire_req_q <= 1'b0;
            fire_x_q   <= '0;
            fire_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            srch_q     <= srch_d;
            fleet_x_q  <= fleet_x_d;
            fleet_y_q  <= fleet_y_d;
            alive_q    <= alive_d;
            score_q    <= score_d;
            dir_q      <= dir_d;
            h_cnt_q    <= h_cnt_d;
            step_q     <= step_d;
            fire_cnt_q <= fire_cnt_d;
            col_q      <= col_d;
            tries_q    <= tries_d;
            kill_ack_q <= kill_ack_d;
            fire_req_q <= fire_req_d;
            fire_x_q   <= fire_x_d;
            fire_y_q   <= fire_y_d;
        end
    end

    assign fleet_x_o    = fleet_x_q;
    assign fleet_y_o    = fleet_y_q;
    assign alive_mask_o = alive_q;
    assign kill_ack_o   = kill_ack_q;
    assign fire_req_o   = fire_req_q;
    assign fire_x_o     = fire_x_q;
    assign fire_y_o     = fire_y_q;
    assign score_o      = score_q;
    assign game_state_o = state_q;
endmodule

// File: tb/tb_fleet_controller.sv
// Bench for fleet_controller: directed scenarios plus random play checked against
// a cycle-level behavioural model of the game rules.
`timescale 1ns/1ps
module tb_fleet_controller;
    localparam int SP = 4, FP = 16, YL = 400;

    logic clk = 1'b0;
    logic reset, start, hit_valid, player_hit, shot_busy;
    logic [4:0] hit_index;
    logic [7:0] rnd;
    logic [9:0] fleet_x, fleet_y, fire_x, fire_y, score;
    logic [23:0] alive;
    logic kill_ack, fire_req;
    logic [1:0] state;

    logic b_start, b_hit_valid;
    logic [4:0] b_hit_index;
    logic [9:0] b_fleet_x, b_fleet_y, b_fire_x, b_fire_y, b_score;
    logic [23:0] b_alive;
    logic b_kill_ack, b_fire_req;
    logic [1:0] b_state;

    int tests_run = 0;
    int tests_failed = 0;

    int m_state, m_x, m_y, m_score, m_dir, m_h, m_step, m_fcnt, m_srch, m_col, m_fx, m_fy;
    bit [23:0] m_alive;
    bit m_kill, m_fire;

    always #5 clk = ~clk;

    fleet_controller #(.STEP_PERIOD(SP), .FIRE_PERIOD(FP), .Y_LIMIT(YL)) dut_a (
        .clk(clk), .reset(reset), .start_i(start), .hit_valid_i(hit_valid),
        .hit_index_i(hit_index), .player_hit_i(player_hit), .shot_busy_i(shot_busy),
        .rand_i(rnd), .fleet_x_o(fleet_x), .fleet_y_o(fleet_y), .alive_mask_o(alive),
        .kill_ack_o(kill_ack), .fire_req_o(fire_req), .fire_x_o(fire_x), .fire_y_o(fire_y),
        .score_o(score), .game_state_o(state));

    fleet_controller #(.STEP_PERIOD(2), .FIRE_PERIOD(16), .Y_LIMIT(190)) dut_b (
        .clk(clk), .reset(reset), .start_i(b_start), .hit_valid_i(b_hit_valid),
        .hit_index_i(b_hit_index), .player_hit_i(1'b0), .shot_busy_i(1'b1),
        .rand_i(rnd), .fleet_x_o(b_fleet_x), .fleet_y_o(b_fleet_y), .alive_mask_o(b_alive),
        .kill_ack_o(b_kill_ack), .fire_req_o(b_fire_req), .fire_x_o(b_fire_x), .fire_y_o(b_fire_y),
        .score_o(b_score), .game_state_o(b_state));

    // Reference model for dut_a: every value is the post-edge expectation.
    always @(posedge clk) begin : model
        bit [23:0] a0;
        int x0, y0, lr, k, ns;
        m_kill = 1'b0;
        m_fire = 1'b0;
        if (reset || (m_state >= 2 && start)) begin
            m_x = 150; m_y = 40; m_alive = '1; m_score = 0; m_dir = 0; m_h = 0;
            m_step = 0; m_fcnt = 0; m_srch = 0; m_col = 0; m_fx = 0; m_fy = 0;
            m_state = reset ? 0 : 1;
        end else if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state >= 2) begin
            m_srch = 0;
        end else begin
            a0 = m_alive; x0 = m_x; y0 = m_y;
            lr = -1;
            for (int i = 0; i < 24; i++) if (a0[i]) lr = i / 8;
            ns = 1;
            if (player_hit || (lr >= 0 && y0 + lr * 50 >= YL)) ns = 3;
            else if (lr < 0) ns = 2;
            if (m_step == SP - 1) begin
                m_step = 0;
                if (m_h < 3) begin m_x = m_dir ? m_x - 60 : m_x + 60; m_h++; end
                else begin m_y += 50; m_dir = !m_dir; m_h = 0; end
            end else m_step++;
            if (hit_valid && hit_index < 24 && a0[hit_index]) begin
                m_alive[hit_index] = 1'b0;
                m_kill = 1'b1;
                if (m_score < 1023) m_score++;
            end
            if (m_srch == 0) begin
                if (m_fcnt == FP - 1) begin
                    m_fcnt = 0;
                    if (!shot_busy) begin m_srch = 8; m_col = rnd % 8; end
                end else m_fcnt++;
            end else begin
                k = -1;
                for (int r = 0; r < 3; r++) if (a0[r * 8 + m_col]) k = r;
                if (k >= 0) begin
                    m_fire = 1'b1; m_fx = x0 + m_col * 60 + 8; m_fy = y0 + k * 50 + 16; m_srch = 0;
                end else begin
                    m_col = (m_col + 1) % 8; m_srch--;
                end
            end
            m_state = ns;
        end
    end

    task automatic restart();
        @(negedge clk); reset = 1'b1; start = 1'b0; hit_valid = 1'b0; player_hit = 1'b0;
        b_start = 1'b0; b_hit_valid = 1'b0;
        @(negedge clk); reset = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        restart();
        hit_valid = 1'b1; hit_index = 5'd5;
        @(negedge clk); hit_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        tests_run++;
        if ({fleet_x, fleet_y, alive, score, state, kill_ack, fire_req, fire_x, fire_y} !==
            {10'd150, 10'd40, 24'hffffff, 10'd0, 2'd0, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            tests_failed++;
            $display("FAIL reset_a: got x=%0d y=%0d alive=%h score=%0d st=%0d ka=%b fr=%b fx=%0d fy=%0d, expected 150 40 ffffff 0 0 0 0 0 0",
                     fleet_x, fleet_y, alive, score, state, kill_ack, fire_req, fire_x, fire_y);
        end
        tests_run++;
        if ({b_fleet_x, b_fleet_y, b_alive, b_score, b_state, b_kill_ack, b_fire_req, b_fire_x, b_fire_y} !==
            {10'd150, 10'd40, 24'hffffff, 10'd0, 2'd0, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            tests_failed++;
            $display("FAIL reset_b: got x=%0d y=%0d alive=%h st=%0d, expected 150 40 ffffff 0", b_fleet_x, b_fleet_y, b_alive, b_state);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if ({fleet_x, state} !== {10'd150, 2'd0}) begin
            tests_failed++;
            $display("FAIL idle_frozen: got x=%0d st=%0d, expected 150 0", fleet_x, state);
        end
    endtask

    task automatic test_march();
        int exp_x[3] = '{270, 210, 150};
        restart();
        tests_run++;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL march_start: got st=%0d expected 1", state); end
        repeat (12) @(negedge clk);
        tests_run++;
        if (fleet_x !== 10'd330) begin tests_failed++; $display("FAIL march_x12: got %0d expected 330", fleet_x); end
        repeat (4) @(negedge clk);
        tests_run++;
        if ({fleet_x, fleet_y} !== {10'd330, 10'd90}) begin
            tests_failed++; $display("FAIL march_descent: got x=%0d y=%0d expected 330 90", fleet_x, fleet_y);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            tests_run++;
            if (fleet_x !== 10'(exp_x[i])) begin
                tests_failed++; $display("FAIL march_left%0d: got %0d expected %0d", i, fleet_x, exp_x[i]);
            end
        end
    endtask

    task automatic test_hits();
        restart();
        repeat (3) @(negedge clk);
        hit_valid = 1'b1; hit_index = 5'd10;
        @(negedge clk); hit_valid = 1'b0;
        tests_run++;
        if ({kill_ack, alive[10], score, fleet_x} !== {1'b1, 1'b0, 10'd1, 10'd210}) begin
            tests_failed++;
            $display("FAIL hit10: got ack=%b bit10=%b score=%0d x=%0d expected 1 0 1 210", kill_ack, alive[10], score, fleet_x);
        end
        @(negedge clk);
        tests_run++;
        if (kill_ack !== 1'b0) begin tests_failed++; $display("FAIL hit_pulse: got ack=%b expected 0", kill_ack); end
        hit_valid = 1'b1; hit_index = 5'd10;
        @(negedge clk); hit_index = 5'd30;
        tests_run++;
        if ({kill_ack, score} !== {1'b0, 10'd1}) begin
            tests_failed++; $display("FAIL hit_dead: got ack=%b score=%0d expected 0 1", kill_ack, score);
        end
        @(negedge clk); hit_valid = 1'b0;
        tests_run++;
        if ({kill_ack, score, alive} !== {1'b0, 10'd1, 24'hfffbff}) begin
            tests_failed++; $display("FAIL hit_range: got ack=%b score=%0d alive=%h expected 0 1 fffbff", kill_ack, score, alive);
        end
    endtask

    task automatic test_kill_all();
        restart();
        for (int i = 0; i < 24; i++) begin
            hit_valid = 1'b1; hit_index = 5'(i);
            @(negedge clk);
        end
        hit_valid = 1'b0;
        tests_run++;
        if ({score, state, alive} !== {10'd24, 2'd1, 24'h0}) begin
            tests_failed++; $display("FAIL killall: got score=%0d st=%0d alive=%h expected 24 1 000000", score, state, alive);
        end
        @(negedge clk);
        tests_run++;
        if ({state, fleet_x, fleet_y} !== {2'd2, 10'd210, 10'd90}) begin
            tests_failed++; $display("FAIL win: got st=%0d x=%0d y=%0d expected 2 210 90", state, fleet_x, fleet_y);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if ({state, fleet_x} !== {2'd2, 10'd210}) begin
            tests_failed++; $display("FAIL win_frozen: got st=%0d x=%0d expected 2 210", state, fleet_x);
        end
    endtask

    task automatic test_fire();
        int fires;
        bit got;
        shot_busy = 1'b0; rnd = 8'd3;
        restart();
        hit_valid = 1'b1; hit_index = 5'd19;
        @(negedge clk); hit_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (fire_req === 1'b1) got = 1'b1; end
        tests_run++;
        if ({got, fire_x, fire_y} !== {1'b1, 10'd518, 10'd156}) begin
            tests_failed++; $display("FAIL fire_col3: got seen=%b fx=%0d fy=%0d expected 1 518 156", got, fire_x, fire_y);
        end
        hit_valid = 1'b1; hit_index = 5'd3;
        @(negedge clk); hit_index = 5'd11;
        @(negedge clk); hit_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (fire_req === 1'b1) got = 1'b1; end
        tests_run++;
        if ({got, fire_x, fire_y} !== {1'b1, 10'd398, 10'd256}) begin
            tests_failed++; $display("FAIL fire_col4: got seen=%b fx=%0d fy=%0d expected 1 398 256", got, fire_x, fire_y);
        end
        shot_busy = 1'b1;
        fires = 0;
        repeat (40) begin @(negedge clk); if (fire_req === 1'b1) fires++; end
        tests_run++;
        if (fires !== 0) begin tests_failed++; $display("FAIL fire_busy: got %0d fire_req pulses expected 0", fires); end
    endtask

    task automatic test_player_hit();
        restart();
        hit_valid = 1'b1; hit_index = 5'd0;
        @(negedge clk); hit_valid = 1'b0; player_hit = 1'b1;
        @(negedge clk); player_hit = 1'b0;
        tests_run++;
        if (state !== 2'd3) begin tests_failed++; $display("FAIL lose_hit: got st=%0d expected 3", state); end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({state, fleet_x, score} !== {2'd3, 10'd150, 10'd1}) begin
            tests_failed++; $display("FAIL lose_hold: got st=%0d x=%0d score=%0d expected 3 150 1", state, fleet_x, score);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        tests_run++;
        if ({state, fleet_x, fleet_y, alive, score} !== {2'd1, 10'd150, 10'd40, 24'hffffff, 10'd0}) begin
            tests_failed++;
            $display("FAIL restart: got st=%0d x=%0d y=%0d alive=%h score=%0d expected 1 150 40 ffffff 0", state, fleet_x, fleet_y, alive, score);
        end
    endtask

    task automatic test_lose_limit();
        int n;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        n = 0;
        while (b_state !== 2'd3 && n < 30) begin @(negedge clk); n++; end
        tests_run++;
        if ({b_state, b_fleet_x, b_fleet_y, 8'(n)} !== {2'd3, 10'd330, 10'd90, 8'd9}) begin
            tests_failed++;
            $display("FAIL lose_limit_full: got st=%0d x=%0d y=%0d cycles=%0d expected 3 330 90 9", b_state, b_fleet_x, b_fleet_y, n);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int i = 16; i < 24; i++) begin
            b_hit_valid = 1'b1; b_hit_index = 5'(i);
            @(negedge clk);
        end
        b_hit_valid = 1'b0;
        n = 0;
        while (b_state !== 2'd3 && n < 30) begin @(negedge clk); n++; end
        tests_run++;
        if ({b_state, b_fleet_x, b_fleet_y, b_score, b_alive} !== {2'd3, 10'd150, 10'd140, 10'd8, 24'h00ffff}) begin
            tests_failed++;
            $display("FAIL lose_limit_row1: got st=%0d x=%0d y=%0d score=%0d alive=%h expected 3 150 140 8 00ffff",
                     b_state, b_fleet_x, b_fleet_y, b_score, b_alive);
        end
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 800; i++) begin
            tests_run++;
            if ({fleet_x, fleet_y, alive, score, state} !==
                {10'(m_x), 10'(m_y), m_alive, 10'(m_score), 2'(m_state)}) begin
                tests_failed++;
                $display("FAIL rand_state@%0d: got x=%0d y=%0d alive=%h score=%0d st=%0d expected %0d %0d %h %0d %0d",
                         i, fleet_x, fleet_y, alive, score, state, m_x, m_y, m_alive, m_score, m_state);
            end
            tests_run++;
            if ({kill_ack, fire_req, fire_x, fire_y} !== {m_kill, m_fire, 10'(m_fx), 10'(m_fy)}) begin
                tests_failed++;
                $display("FAIL rand_pulses@%0d: got ka=%b fr=%b fx=%0d fy=%0d expected %b %b %0d %0d",
                         i, kill_ack, fire_req, fire_x, fire_y, m_kill, m_fire, m_fx, m_fy);
            end
            hit_valid  = ($urandom % 3) == 0;
            hit_index  = 5'($urandom % 32);
            player_hit = ($urandom % 150) == 0;
            shot_busy  = ($urandom % 4) == 0;
            start      = ($urandom % 20) == 0;
            rnd        = 8'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_index = '0; player_hit = 1'b0;
        shot_busy = 1'b1; rnd = '0; b_start = 1'b0; b_hit_valid = 1'b0; b_hit_index = '0;
        test_reset();
        test_march();
        test_hits();
        test_kill_all();
        test_fire();
        test_player_hit();
        test_lose_limit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t, expected completion earlier", $time);
        $fatal(1);
    end
endmodule
